// File: rtl/ym2203_bank_pkg.sv
// Shared constants for the YM2203 bank: divider-limit tables, chip-select command,
// prescaler register addresses and mix accumulator guard width.
package ym2203_bank_pkg;

    localparam logic [4:0] SEL_CMD      = 5'b11111;
    localparam logic [7:0] REG_PRES_HI  = 8'h2D;
    localparam logic [7:0] REG_PRES_LO  = 8'h2E;
    localparam logic [7:0] REG_PRES_CLR = 8'h2F;
    localparam logic [1:0] PRES_RESET   = 2'd2;
    localparam int         MIX_GUARD_W  = 4;

    // Divider terminal count per prescaler setting; the divider period is limit+1.
    function automatic logic [2:0] opn_limit(input logic [1:0] pres);
        case (pres)
            2'd0:    return 3'd1;
            2'd1:    return 3'd1;
            2'd2:    return 3'd5;
            default: return 3'd2;
        endcase
    endfunction

    function automatic logic [1:0] psg_limit(input logic [1:0] pres);
        case (pres)
            2'd0:    return 2'd0;
            2'd1:    return 2'd0;
            2'd2:    return 2'd3;
            default: return 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/jt12.sv
// Register-level stand-in for the jt12 FM core: idle status on read and a 12-bit
// sample held in registers 0x10 (low) / 0x11 (high nibble), output on the OPN clock enable.
module jt12 (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cen,
    input  logic        i_cs,
    input  logic        i_we,
    input  logic        i_a0,
    input  logic [7:0]  i_di,
    output logic [7:0]  o_dout,
    output logic [11:0] o_snd
);

    logic [7:0]  r_addr;
    logic [11:0] r_sample;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr   <= 8'h00;
            r_sample <= 12'h000;
            o_snd    <= 12'h000;
        end else begin
            if (i_cs && i_we) begin
                if (!i_a0)                r_addr          <= i_di;
                else if (r_addr == 8'h10) r_sample[7:0]   <= i_di;
                else if (r_addr == 8'h11) r_sample[11:8]  <= i_di[3:0];
            end
            if (i_cen) o_snd <= r_sample;
        end
    end

    assign o_dout = 8'h00;

endmodule

// File: rtl/ym2149.sv
// Register-level stand-in for the ym2149 PSG core: 16 registers, channel levels
// taken from registers 8/9/10 and updated on the PSG clock enable.
module ym2149 (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_cen,
    input  logic       i_we,
    input  logic       i_a0,
    input  logic [7:0] i_di,
    output logic [7:0] o_dout,
    output logic [7:0] o_a,
    output logic [7:0] o_b,
    output logic [7:0] o_c,
    output logic       o_active
);

    logic [3:0] r_addr;
    logic       r_addr_ok;
    logic [7:0] r_regs [16];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr    <= 4'd0;
            r_addr_ok <= 1'b1;
            for (int i = 0; i < 16; i++) r_regs[i] <= 8'h00;
            o_a <= 8'h00;
            o_b <= 8'h00;
            o_c <= 8'h00;
        end else begin
            if (i_we && !i_a0) begin
                r_addr    <= i_di[3:0];
                r_addr_ok <= (i_di[7:4] == 4'h0);
            end else if (i_we && r_addr_ok) begin
                r_regs[r_addr] <= i_di;
            end
            if (i_cen) begin
                o_a <= r_regs[8];
                o_b <= r_regs[9];
                o_c <= r_regs[10];
            end
        end
    end

    assign o_dout   = r_regs[r_addr];
    assign o_active = |{o_a, o_b, o_c};

endmodule

// File: rtl/ym2203_slot.sv
// One YM2203 slot: prescaler tracking, free-running OPN/PSG clock-enable dividers,
// and the PSG and FM cores driven by those enables.
module ym2203_slot (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ce_ym,
    input  logic        i_fm_en,
    input  logic        i_we,
    input  logic        i_a0,
    input  logic [7:0]  i_di,
    output logic [7:0]  o_psg_a,
    output logic [7:0]  o_psg_b,
    output logic [7:0]  o_psg_c,
    output logic [11:0] o_fm,
    output logic [7:0]  o_psg_dout,
    output logic [7:0]  o_fm_dout,
    output logic        o_psg_active
);
    import ym2203_bank_pkg::*;

    logic [7:0] r_ymreg;
    logic [1:0] r_pres;
    logic [2:0] r_div_opn;
    logic [1:0] r_div_psg;
    logic       r_ce_opn;
    logic       r_ce_psg;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ymreg <= 8'h00;
            r_pres  <= PRES_RESET;
        end else if (i_we && i_fm_en) begin
            if (!i_a0) begin
                r_ymreg <= i_di;
            end else begin
                case (r_ymreg)
                    REG_PRES_HI:  r_pres[1] <= 1'b1;
                    REG_PRES_LO:  r_pres[0] <= 1'b1;
                    REG_PRES_CLR: r_pres    <= 2'd0;
                    default: ;
                endcase
            end
        end
    end

    // Dividers never restart on a prescaler change; an out-of-range count wraps on the next tick.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div_opn <= 3'd0;
            r_div_psg <= 2'd0;
            r_ce_opn  <= 1'b0;
            r_ce_psg  <= 1'b0;
        end else begin
            r_ce_opn <= 1'b0;
            r_ce_psg <= 1'b0;
            if (i_ce_ym) begin
                r_div_opn <= (r_div_opn >= opn_limit(r_pres)) ? 3'd0 : r_div_opn + 3'd1;
                r_div_psg <= (r_div_psg >= psg_limit(r_pres)) ? 2'd0 : r_div_psg + 2'd1;
                r_ce_opn  <= (r_div_opn == 3'd0);
                r_ce_psg  <= (r_div_psg == 2'd0);
            end
        end
    end

    ym2149 u_psg (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_cen    (r_ce_psg),
        .i_we     (i_we),
        .i_a0     (i_a0),
        .i_di     (i_di),
        .o_dout   (o_psg_dout),
        .o_a      (o_psg_a),
        .o_b      (o_psg_b),
        .o_c      (o_psg_c),
        .o_active (o_psg_active)
    );

    jt12 u_fm (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_cen   (r_ce_opn),
        .i_cs    (i_fm_en),
        .i_we    (i_we),
        .i_a0    (i_a0),
        .i_di    (i_di),
        .o_dout  (o_fm_dout),
        .o_snd   (o_fm)
    );

endmodule

// File: rtl/ym2203_bank.sv
// Bank of NUM_CHIPS YM2203 slots behind one CPU port with a saturating 3-stage mixer.
// Define YM2203_BANK_STEREO_EN for A+B/2 left, C+B/2 right PSG panning; otherwise mono.
module ym2203_bank #(
    parameter int NUM_CHIPS = 2,
    parameter int OUT_W     = 16,
    parameter int PSG_SHIFT = 4,
    parameter int FM_SHIFT  = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CE_CPU,
    input  logic             CE_YM,
    input  logic             A0,
    input  logic             WE,
    input  logic [7:0]       DI,
    output logic [7:0]       DO,
    input  logic             FM_ENA,
    output logic [1:0]       SEL_CHIP,
    output logic [OUT_W-1:0] AUDIO_L,
    output logic [OUT_W-1:0] AUDIO_R,
    output logic             PSG_ACTIVE
);
    import ym2203_bank_pkg::*;

    localparam int ACC_W = OUT_W + MIX_GUARD_W;
    localparam logic signed [ACC_W-1:0] SAT_MAX = $signed({{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN = $signed({{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});

    logic                   w_wr;
    logic                   w_sel_cmd;
    logic [1:0]             w_cmd_idx;
    logic [1:0]             r_sel;
    logic [NUM_CHIPS-1:0]   r_fm_off;
    logic [NUM_CHIPS-1:0]   w_fm_cs;
    logic [NUM_CHIPS-1:0]   w_slot_we;
    logic [NUM_CHIPS-1:0]   w_psg_act;
    logic [7:0]             w_psg_a    [NUM_CHIPS];
    logic [7:0]             w_psg_b    [NUM_CHIPS];
    logic [7:0]             w_psg_c    [NUM_CHIPS];
    logic [11:0]            w_fm       [NUM_CHIPS];
    logic [7:0]             w_psg_dout [NUM_CHIPS];
    logic [7:0]             w_fm_dout  [NUM_CHIPS];
    logic [9:0]             r_s1_psg_l [NUM_CHIPS];
    logic [9:0]             r_s1_psg_r [NUM_CHIPS];
    logic signed [11:0]     r_s1_fm    [NUM_CHIPS];
    logic signed [ACC_W-1:0] w_sum_l, w_sum_r, r_s2_l, r_s2_r;

    assign w_wr      = CE_CPU & WE;
    assign w_cmd_idx = ~DI[1:0];
    assign w_sel_cmd = w_wr & ~A0 & (DI[7:3] == SEL_CMD);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sel    <= 2'd0;
            r_fm_off <= '0;
        end else if (w_sel_cmd && (int'(w_cmd_idx) < NUM_CHIPS)) begin
            r_sel <= w_cmd_idx;
            for (int i = 0; i < NUM_CHIPS; i++)
                if (w_cmd_idx == 2'(i)) r_fm_off[i] <= DI[2];
        end
    end

    generate
        for (genvar g = 0; g < NUM_CHIPS; g++) begin : g_slot
            assign w_fm_cs[g]   = FM_ENA & ~r_fm_off[g];
            assign w_slot_we[g] = w_wr & ~w_sel_cmd & (r_sel == 2'(g));

            ym2203_slot u_slot (
                .i_clk        (CLK),
                .i_reset      (RESET),
                .i_ce_ym      (CE_YM),
                .i_fm_en      (w_fm_cs[g]),
                .i_we         (w_slot_we[g]),
                .i_a0         (A0),
                .i_di         (DI),
                .o_psg_a      (w_psg_a[g]),
                .o_psg_b      (w_psg_b[g]),
                .o_psg_c      (w_psg_c[g]),
                .o_fm         (w_fm[g]),
                .o_psg_dout   (w_psg_dout[g]),
                .o_fm_dout    (w_fm_dout[g]),
                .o_psg_active (w_psg_act[g])
            );
        end
    endgenerate

    always_comb begin
        DO = 8'hFF;
        for (int i = 0; i < NUM_CHIPS; i++)
            if (r_sel == 2'(i)) DO = A0 ? w_psg_dout[i] : (w_fm_cs[i] ? w_fm_dout[i] : 8'hFF);
    end

    assign SEL_CHIP   = r_sel;
    assign PSG_ACTIVE = |w_psg_act;

    // Stage 1: per-slot PSG channel sums and gated FM sample.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_CHIPS; i++) begin
            if (RESET) begin
                r_s1_psg_l[i] <= 10'd0;
                r_s1_psg_r[i] <= 10'd0;
                r_s1_fm[i]    <= 12'sd0;
            end else begin
`ifdef YM2203_BANK_STEREO_EN
                r_s1_psg_l[i] <= 10'(w_psg_a[i]) + (10'(w_psg_b[i]) >> 1);
                r_s1_psg_r[i] <= 10'(w_psg_c[i]) + (10'(w_psg_b[i]) >> 1);
`else
                r_s1_psg_l[i] <= 10'(w_psg_a[i]) + 10'(w_psg_b[i]) + 10'(w_psg_c[i]);
                r_s1_psg_r[i] <= 10'(w_psg_a[i]) + 10'(w_psg_b[i]) + 10'(w_psg_c[i]);
`endif
                r_s1_fm[i]    <= w_fm_cs[i] ? $signed(w_fm[i]) : 12'sd0;
            end
        end
    end

    always_comb begin
        w_sum_l = '0;
        w_sum_r = '0;
        for (int i = 0; i < NUM_CHIPS; i++) begin
            w_sum_l = w_sum_l + ($signed(ACC_W'(r_s1_psg_l[i])) <<< PSG_SHIFT) + (ACC_W'(r_s1_fm[i]) <<< FM_SHIFT);
            w_sum_r = w_sum_r + ($signed(ACC_W'(r_s1_psg_r[i])) <<< PSG_SHIFT) + (ACC_W'(r_s1_fm[i]) <<< FM_SHIFT);
        end
    end

    function automatic logic [OUT_W-1:0] sat(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) return SAT_MAX[OUT_W-1:0];
        if (v < SAT_MIN) return SAT_MIN[OUT_W-1:0];
        return v[OUT_W-1:0];
    endfunction

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_s2_l  <= '0;
            r_s2_r  <= '0;
            AUDIO_L <= '0;
            AUDIO_R <= '0;
        end else begin
            r_s2_l  <= w_sum_l;
            r_s2_r  <= w_sum_r;
            AUDIO_L <= sat(r_s2_l);
            AUDIO_R <= sat(r_s2_r);
        end
    end

endmodule
